// File: rtl/prog_mux_func_unit_if.sv
// Bus bundle for prog_mux_func_unit. It carries the table-load, evaluation and
// sweep handshakes. The driver uses the master side and the function unit uses the slave side.
interface prog_mux_func_unit_if #(
    parameter int N_IN = 4
);
    logic              cfg_start;
    logic              cfg_valid;
    logic [1:0]        cfg_code;
    logic              cfg_ready;
    logic              cfg_done;
    logic              in_valid;
    logic [N_IN-1:0]   in_vars;
    logic              in_ready;
    logic              out_valid;
    logic              out_f;
    logic              sweep_start;
    logic              sweep_busy;
    logic [N_IN-1:0]   sweep_vec;
    logic [N_IN:0]     sweep_count;
    logic              sweep_done;

    modport master (
        output cfg_start, cfg_valid, cfg_code, in_valid, in_vars, sweep_start,
        input  cfg_ready, cfg_done, in_ready, out_valid, out_f,
               sweep_busy, sweep_vec, sweep_count, sweep_done
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_code, in_valid, in_vars, sweep_start,
        output cfg_ready, cfg_done, in_ready, out_valid, out_f,
               sweep_busy, sweep_vec, sweep_count, sweep_done
    );
endinterface

// File: rtl/prog_mux_func_unit.sv
// Programmable N_IN-variable boolean function built as a 2^(N_IN-1):1 mux with residue legs.
// It has a handshaked table load, single-vector evaluation and an exhaustive minterm-counting sweep.
module prog_mux_func_unit #(
    parameter  int N_IN    = 4,
    localparam int ENTRIES = 2 ** (N_IN - 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    prog_mux_func_unit_if.slave  bus
);
    localparam logic [1:0]      IDLE     = 2'd0;
    localparam logic [1:0]      LOAD     = 2'd1;
    localparam logic [1:0]      SWEEP    = 2'd2;
    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1'b1);
    localparam logic [N_IN-2:0] LAST_PTR = {(N_IN-1){1'b1}};
    localparam logic [N_IN-2:0] PTR_ONE  = (N_IN-1)'(1'b1);

    logic [1:0]      state_q, state_d;
    logic [1:0]      table_q [ENTRIES];
    logic [1:0]      table_d [ENTRIES];
    logic [N_IN-2:0] ptr_q, ptr_d;
    logic            out_valid_q, out_valid_d;
    logic            out_f_q, out_f_d;
    logic [N_IN-1:0] sweep_vec_q, sweep_vec_d;
    logic [N_IN:0]   sweep_count_q, sweep_count_d;
    logic            sweep_done_q, sweep_done_d;
    logic            cfg_done_q, cfg_done_d;

    logic [N_IN-1:0] next_vec_s;
    logic            eval_f_s;
    logic            next_f_s;
    logic            first_f_s;

    function automatic logic leg_decode(input logic [1:0] code, input logic d);
        logic f;
        case (code)
            2'b00:   f = 1'b0;
            2'b01:   f = 1'b1;
            2'b10:   f = d;
            2'b11:   f = ~d;
            default: f = 1'b0;
        endcase
        return f;
    endfunction

    assign next_vec_s = sweep_vec_q + VEC_ONE;
    assign eval_f_s   = leg_decode(table_q[bus.in_vars[N_IN-1:1]], bus.in_vars[0]);
    assign next_f_s   = leg_decode(table_q[next_vec_s[N_IN-1:1]], next_vec_s[0]);
    assign first_f_s  = leg_decode(table_q[0], 1'b0);

    // Next-state and datapath selection for the IDLE / LOAD / SWEEP controller
    always_comb begin
        state_d       = state_q;
        table_d       = table_q;
        ptr_d         = ptr_q;
        out_valid_d   = 1'b0;
        out_f_d       = out_f_q;
        sweep_vec_d   = sweep_vec_q;
        sweep_count_d = sweep_count_q;
        sweep_done_d  = 1'b0;
        cfg_done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cfg_start) begin
                    state_d = LOAD;
                    ptr_d   = {(N_IN-1){1'b0}};
                end else if (bus.sweep_start) begin
                    // Vector 0 is presented on the very next cycle, so it is counted here.
                    state_d       = SWEEP;
                    sweep_vec_d   = {N_IN{1'b0}};
                    out_valid_d   = 1'b1;
                    out_f_d       = first_f_s;
                    sweep_count_d = {{N_IN{1'b0}}, first_f_s};
                end else if (bus.in_valid) begin
                    out_valid_d = 1'b1;
                    out_f_d     = eval_f_s;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (bus.cfg_start) begin
                    ptr_d = {(N_IN-1){1'b0}};
                end else if (bus.cfg_valid) begin
                    table_d[ptr_q] = bus.cfg_code;
                    ptr_d          = ptr_q + PTR_ONE;
                    if (ptr_q == LAST_PTR) begin
                        state_d    = IDLE;
                        cfg_done_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            SWEEP: begin
                sweep_vec_d = next_vec_s;
                if (sweep_vec_q == LAST_VEC) begin
                    state_d = IDLE;
                end else begin
                    out_valid_d   = 1'b1;
                    out_f_d       = next_f_s;
                    sweep_count_d = sweep_count_q + {{N_IN{1'b0}}, next_f_s};
                    sweep_done_d  = (next_vec_s == LAST_VEC);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset that also clears the code table
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= 2'b00;
            end
            ptr_q         <= {(N_IN-1){1'b0}};
            out_valid_q   <= 1'b0;
            out_f_q       <= 1'b0;
            sweep_vec_q   <= {N_IN{1'b0}};
            sweep_count_q <= {(N_IN+1){1'b0}};
            sweep_done_q  <= 1'b0;
            cfg_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            table_q       <= table_d;
            ptr_q         <= ptr_d;
            out_valid_q   <= out_valid_d;
            out_f_q       <= out_f_d;
            sweep_vec_q   <= sweep_vec_d;
            sweep_count_q <= sweep_count_d;
            sweep_done_q  <= sweep_done_d;
            cfg_done_q    <= cfg_done_d;
        end
    end

    assign bus.cfg_ready   = (state_q == LOAD);
    assign bus.in_ready    = (state_q == IDLE);
    assign bus.sweep_busy  = (state_q == SWEEP);
    assign bus.cfg_done    = cfg_done_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_f       = out_f_q;
    assign bus.sweep_vec   = sweep_vec_q;
    assign bus.sweep_count = sweep_count_q;
    assign bus.sweep_done  = sweep_done_q;
endmodule

// File: tb/tb_prog_mux_func_unit.sv
// Self-checking bench for prog_mux_func_unit: N_IN=4 instance against a truth-table model,
// plus a small N_IN=2 instance for the all-ones count boundary.
module tb_prog_mux_func_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prog_mux_func_unit_if #(.N_IN(4)) b4 ();
    prog_mux_func_unit_if #(.N_IN(2)) b2 ();

    prog_mux_func_unit #(.N_IN(4)) dut  (.clk(clk), .rst(rst), .bus(b4));
    prog_mux_func_unit #(.N_IN(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    int checks = 0;
    int errors = 0;
    logic [1:0] mtab [8];

    typedef struct {
        logic [3:0] vars;
        logic       exp_f;
    } vec_t;
    vec_t vecs [4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: the function value of vector v from the leg code chosen by v/2.
    function automatic int ref_f(input int v);
        int d;
        d = v % 2;
        case (mtab[v / 2])
            2'b00:   return 0;
            2'b01:   return 1;
            2'b10:   return d;
            default: return 1 - d;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear4();
        b4.cfg_start = 1'b0; b4.cfg_valid = 1'b0; b4.cfg_code = 2'b00;
        b4.in_valid = 1'b0; b4.in_vars = 4'd0; b4.sweep_start = 1'b0;
    endtask

    task automatic load4(input logic [15:0] codes);
        b4.cfg_start = 1'b1;
        tick();
        b4.cfg_start = 1'b0;
        chk("load_ready", int'(b4.cfg_ready), 1);
        for (int i = 0; i < 8; i++) begin
            b4.cfg_valid = 1'b1;
            b4.cfg_code  = codes[2*i +: 2];
            mtab[i]      = codes[2*i +: 2];
            tick();
            chk("load_done", int'(b4.cfg_done), (i == 7) ? 1 : 0);
        end
        b4.cfg_valid = 1'b0;
        chk("load_exit_ready", int'(b4.cfg_ready), 0);
        tick();
        chk("load_done_pulse", int'(b4.cfg_done), 0);
    endtask

    task automatic sweep4(output int total);
        int exp_cnt;
        exp_cnt = 0;
        b4.sweep_start = 1'b1;
        tick();
        b4.sweep_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_cnt += ref_f(k);
            chk("sw_valid", int'(b4.out_valid), 1);
            chk("sw_busy", int'(b4.sweep_busy), 1);
            chk("sw_vec", int'(b4.sweep_vec), k);
            chk("sw_f", int'(b4.out_f), ref_f(k));
            chk("sw_count", int'(b4.sweep_count), exp_cnt);
            chk("sw_done", int'(b4.sweep_done), (k == 15) ? 1 : 0);
            tick();
        end
        chk("sw_exit_busy", int'(b4.sweep_busy), 0);
        chk("sw_exit_ready", int'(b4.in_ready), 1);
        chk("sw_exit_valid", int'(b4.out_valid), 0);
        chk("sw_hold_count", int'(b4.sweep_count), exp_cnt);
        total = exp_cnt;
    endtask

    initial begin
        int   total;
        logic pv;
        logic [3:0] pvars;

        clear4();
        b2.cfg_start = 1'b0; b2.cfg_valid = 1'b0; b2.cfg_code = 2'b00;
        b2.in_valid = 1'b0; b2.in_vars = 2'd0; b2.sweep_start = 1'b0;
        for (int i = 0; i < 8; i++) mtab[i] = 2'b00;

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", int'(b4.in_ready), 1);
        chk("rst_out_valid", int'(b4.out_valid), 0);
        chk("rst_out_f", int'(b4.out_f), 0);
        chk("rst_cfg_ready", int'(b4.cfg_ready), 0);
        chk("rst_busy", int'(b4.sweep_busy), 0);
        chk("rst_count", int'(b4.sweep_count), 0);
        chk("rst_done", int'(b4.sweep_done) + int'(b4.cfg_done), 0);

        sweep4(total);
        chk("empty_total", total, 0);

        // Sum of minterms 1,2,6,7,11,14.
        load4(16'b11_00_10_00_01_00_11_10);
        sweep4(total);
        chk("plan_total", total, 6);

        vecs[0] = '{4'b0001, 1'b1};
        vecs[1] = '{4'b1011, 1'b1};
        vecs[2] = '{4'b1110, 1'b1};
        vecs[3] = '{4'b1111, 1'b0};
        for (int i = 0; i < 4; i++) begin
            b4.in_valid = 1'b1;
            b4.in_vars  = vecs[i].vars;
            tick();
            chk("b2b_valid", int'(b4.out_valid), 1);
            chk("b2b_f", int'(b4.out_f), int'(vecs[i].exp_f));
        end
        b4.in_valid = 1'b0;
        tick();
        chk("b2b_idle_valid", int'(b4.out_valid), 0);

        // Simultaneous commands: load wins, then restart after three beats.
        b4.cfg_start = 1'b1; b4.sweep_start = 1'b1; b4.in_valid = 1'b1; b4.in_vars = 4'b0001;
        tick();
        clear4();
        chk("sim_cfg_ready", int'(b4.cfg_ready), 1);
        chk("sim_out_valid", int'(b4.out_valid), 0);
        chk("sim_busy", int'(b4.sweep_busy), 0);
        for (int i = 0; i < 3; i++) begin
            b4.cfg_valid = 1'b1; b4.cfg_code = 2'b01;
            b4.in_valid = 1'b1; b4.sweep_start = 1'b1;
            tick();
            chk("mid_done", int'(b4.cfg_done), 0);
            chk("mid_valid", int'(b4.out_valid), 0);
            chk("mid_in_ready", int'(b4.in_ready), 0);
        end
        b4.in_valid = 1'b0; b4.sweep_start = 1'b0;
        b4.cfg_start = 1'b1; b4.cfg_valid = 1'b1; b4.cfg_code = 2'b01;
        tick();
        b4.cfg_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b4.cfg_valid = 1'b1;
            b4.cfg_code  = (i % 2 == 0) ? 2'b10 : 2'b00;
            mtab[i]      = b4.cfg_code;
            tick();
            chk("restart_done", int'(b4.cfg_done), (i == 7) ? 1 : 0);
        end
        b4.cfg_valid = 1'b0;
        tick();
        sweep4(total);
        chk("restart_total", total, 4);

        // Random loads, evaluations with stray cfg beats, and sweeps.
        for (int r = 0; r < 3; r++) begin
            load4(16'($urandom));
            pv = 1'b0;
            for (int i = 0; i < 40; i++) begin
                b4.in_valid  = 1'($urandom_range(0, 1));
                b4.in_vars   = 4'($urandom);
                b4.cfg_valid = 1'($urandom_range(0, 1));
                b4.cfg_code  = 2'($urandom);
                pv    = b4.in_valid;
                pvars = b4.in_vars;
                tick();
                chk("rnd_valid", int'(b4.out_valid), int'(pv));
                if (pv) chk("rnd_f", int'(b4.out_f), ref_f(int'(pvars)));
            end
            clear4();
            tick();
            sweep4(total);
        end

        // All-ones table counts 16 without wrap, then reset in the 5th sweep cycle.
        load4(16'h5555);
        sweep4(total);
        chk("ones_total", total, 16);
        b4.sweep_start = 1'b1;
        tick();
        b4.sweep_start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("pre_rst_vec", int'(b4.sweep_vec), 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", int'(b4.sweep_busy), 0);
        chk("abort_ready", int'(b4.in_ready), 1);
        chk("abort_valid", int'(b4.out_valid), 0);
        chk("abort_f", int'(b4.out_f), 0);
        chk("abort_count", int'(b4.sweep_count), 0);
        chk("abort_vec", int'(b4.sweep_vec), 0);
        for (int i = 0; i < 8; i++) mtab[i] = 2'b00;
        sweep4(total);
        chk("abort_total", total, 0);

        // N_IN=2: two legs of constant 1 give a count of 4.
        b2.cfg_start = 1'b1;
        tick();
        b2.cfg_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            b2.cfg_valid = 1'b1; b2.cfg_code = 2'b01;
            tick();
            chk("n2_done", int'(b2.cfg_done), (i == 1) ? 1 : 0);
        end
        b2.cfg_valid = 1'b0;
        b2.sweep_start = 1'b1;
        tick();
        b2.sweep_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("n2_vec", int'(b2.sweep_vec), k);
            chk("n2_f", int'(b2.out_f), 1);
            chk("n2_count", int'(b2.sweep_count), k + 1);
            chk("n2_sdone", int'(b2.sweep_done), (k == 3) ? 1 : 0);
            tick();
        end
        chk("n2_exit_busy", int'(b2.sweep_busy), 0);
        chk("n2_hold_count", int'(b2.sweep_count), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prog_mux_func_unit.md
Name: prog_mux_func_unit

Overview:
- Programmable, registered successor to the fixed 8:1-mux boolean-function block.
- Realises any N_IN-variable function F by MUX residue mapping:
  - The top N_IN-1 variables drive the select lines.
  - The LSB variable is the residue input.
  - Each mux leg holds a 2-bit code: constant 0, constant 1, d or ~d.
- The code table is loaded over a valid/ready handshake. Single-vector evaluation is handshaked with 1-cycle latency.
- A self-sweep mode walks all 2^N_IN input vectors and counts the minterms. It serves as the lab's function checker.

Parameters:
- N_IN, 4, number of function variables; legal range 2..8.
- ENTRIES, 2**(N_IN-1), number of mux legs (derived, do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  begin or restart table load; write pointer returns to 0.
- cfg_valid  in  1  cfg_code beat valid.
- cfg_code  in  2  leg code: 00=0, 01=1, 10=d, 11=~d.
- cfg_ready  out  1  high while in LOAD.
- cfg_done  out  1  1-cycle pulse after the last leg is written.
- in_valid  in  1  evaluation request.
- in_vars  in  N_IN  variables; bit N_IN-1 = a (MSB select) ... bit 1 = LSB select; bit 0 = residue d.
- in_ready  out  1  high only in IDLE.
- out_valid  out  1  out_f valid this cycle.
- out_f  out  1  function value.
- sweep_start  in  1  start exhaustive sweep.
- sweep_busy  out  1  high in SWEEP.
- sweep_vec  out  N_IN  vector that produced the current out_f; meaningful when out_valid is high in SWEEP.
- sweep_count  out  N_IN+1  number of vectors with F=1.
- sweep_done  out  1  1-cycle pulse.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State becomes IDLE; all table entries become 00; the write pointer becomes 0.
  - All outputs become 0 except in_ready, which is 1 since the state is IDLE.
  - Reset mid-LOAD or mid-SWEEP aborts the operation; the partial load is discarded because the table is cleared.
- Evaluation rule: sel = in_vars[N_IN-1:1]; F = decode(table[sel], in_vars[0]).
- States:
  - IDLE: accepts one command per cycle.
    - Priority: cfg_start > sweep_start > in_valid.
    - cfg_start -> LOAD with ptr=0.
    - sweep_start -> SWEEP with vec=0 and count=0.
    - in_valid && in_ready -> out_valid=1 and out_f=F(in_vars) on the next cycle. Back-to-back requests give one result per cycle.
  - LOAD: cfg_ready=1.
    - Each cycle with cfg_valid=1 writes table[ptr]=cfg_code and increments ptr.
    - On the write with ptr==ENTRIES-1: cfg_done=1 on the next cycle and the state returns to IDLE.
    - cfg_start in LOAD resets ptr to 0 (restart) and takes priority over a simultaneous beat; that beat is dropped.
    - sweep_start and in_valid are ignored; in_ready=0.
  - SWEEP: assume sweep_start is accepted at edge T.
    - For k = 0 .. 2^N_IN-1, cycle T+1+k has out_valid=1, sweep_vec=k and out_f=F(k).
    - sweep_count increments in the same cycle its vector's out_f=1 is presented and holds the final total when sweep_done=1.
    - sweep_done=1 in cycle T+2^N_IN, together with the last vector.
    - The state is IDLE in cycle T+2^N_IN+1.
    - sweep_count holds its value until the next sweep_start or reset.
    - cfg_start, sweep_start and in_valid are ignored while busy.
- out_valid is 0 whenever no result is presented. out_f holds its last value when out_valid=0.
- sweep_count width N_IN+1 lets it hold 2^N_IN (all-ones table) without wrap.
- The vector counter wraps from 2^N_IN-1 only at exit; no vector is repeated.
- cfg_valid outside LOAD is ignored; no write occurs.

Test Plan:
- Reset then sweep with N_IN=4 -> 16 outputs all 0, sweep_count=0, sweep_done in cycle T+16.
- Load codes [10,11,00,01,00,10,00,11] for legs 0..7 (F=Σm(1,2,6,7,11,14)), then sweep:
  - out_f=1 exactly for vectors 1,2,6,7,11,14.
  - sweep_count=6 and cfg_done pulses once.
- After that load, evaluate back-to-back in_vars 0001, 1011, 1110, 1111 -> out_f 1,1,1,0 on consecutive cycles, each one cycle after its request.
- Simultaneous events:
  - cfg_start+sweep_start+in_valid in IDLE -> LOAD entered, no out_valid, no sweep.
  - cfg_start mid-load after 3 beats -> ptr=0; 8 further beats needed before cfg_done.
- Reset asserted in the 5th sweep cycle -> next cycle IDLE, outputs 0, table all 00 (a subsequent sweep gives count 0).
- All-ones load (all 01) with N_IN=4 -> sweep_count=16, no wrap. Repeat the load with N_IN=2 -> sweep_count=4.
